bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Parametrised, enable-gated decimal event counter with 7-segment output, successor to the fixed 6-digit hex seconds counter on the game board. It combines a programmable rate divider, an N-digit BCD up/down counter with saturation, parallel load and countdown-expiry pulse, and per-digit segment decode with optional leading-zero blanking. It sits between the board clock and the HEX displays and serves as the game timer, countdown timer and score display.

## Interface
- `DIGITS`, 6: number of BCD digits and displays, 1..8.
- `TICK_DIV`, 50_000_000: clock cycles per count tick, ≥ 2.
- `BLANK_LEADING`, 1: 1 blanks leading zero digits; 0 shows all digits.

- `clock`  in  1: system clock.
- `reset`  in  1: synchronous, active-low.
- `enable`  in  1: run/pause for the divider and counter.
- `count_down`  in  1: 0 counts up, 1 counts down.
- `load`  in  1: parallel load strobe.
- `load_bcd`  in  4*DIGITS: load value, digit 0 in [3:0].
- `bcd`  out  4*DIGITS: current count, registered.
- `hex`  out  7*DIGITS: segments, digit k in [7k+6:7k], active-low, order gfedcba.
- `tick`  out  1: one-cycle count strobe.
- `at_limit`  out  1: count is at its saturation bound for the current direction.
- `expired`  out  1: one-cycle pulse when a down-count reaches zero.

## Operation
- **Divider** `div`, width clog2(TICK_DIV):
  - Reset value is TICK_DIV-1.
  - On each cycle with `enable`=1: if `div`==0, reload TICK_DIV-1; otherwise decrement.
  - Holds when `enable`=0.
- **`tick`** = `enable` & (`div`==0). It is combinational and never high while paused.
- **Counter**, evaluated at each edge in this priority:
  1. `reset`=0 gives `bcd`=0.
  2. `load` loads `load_bcd`, and also sets `div` to TICK_DIV-1. Any load nibble >9 is clamped to 9.
  3. `tick` with up-count: decimal increment with ripple carry (9 becomes 0, carry to the next digit). The count saturates at all-9s and holds there.
  4. `tick` with down-count: decimal decrement with ripple borrow. The count saturates at 0 and holds there.
  5. Otherwise hold.
- **`at_limit`** is combinational: `count_down` ? (`bcd`==0) : (`bcd`==all-9s).
- **`expired`** is registered. It is 1 for exactly one cycle, the cycle after the edge where a down-tick changed `bcd` from a nonzero value to 0. It does not fire on load-to-zero, reset, or a tick while already at 0.
- **`count_down`** may change at any time. It affects only the next tick and does not disturb `div`.
- **Decode**, per digit:
  - Values 0..9 use the standard active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - A blanked digit outputs 1111111.
  - With `BLANK_LEADING`=1, a digit k≥1 is blanked when it and every higher digit are 0. Digit 0 is never blanked.

## Timing
- After reset (held ≥1 cycle):
  - `bcd`=0, `div`=TICK_DIV-1, `expired`=0, `tick`=0.
  - `hex` digit0=1000000. Other digits are 1111111 if `BLANK_LEADING`=1, else 1000000.
  - `at_limit` = `count_down`.
- The first `tick` is high in the TICK_DIV-th enabled cycle after reset or load. Later ticks follow every TICK_DIV enabled cycles.
- `bcd` changes at the clock edge where `tick` is high. `hex` and `at_limit` follow combinationally in the same cycle.
- `load` has a one-cycle latency to `bcd`. A simultaneous `load` and `tick` applies the load; the tick is discarded.
- Reset mid-period discards the partial period. Pausing mid-period preserves it exactly.

## Structure
- Shared package `bcd_display_pkg` holds:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - The digit-width localparam (4) and segment width (7).
  - Function `bcd_clamp` (nibble → min(nibble, 9)).
- Sub-module `bcd_seg7_decoder`, combinational, ports `digit[3:0]`, `blank`, `segments[6:0]`. It is instantiated DIGITS times via generate.
- The divider, counter, carry/borrow chain, blanking chain and expiry register stay in the top module.

## Test plan
Bench uses TICK_DIV=4, DIGITS=3.
- **Reset and first ticks:** reset, then `enable`=1 up-count for 12 cycles → ticks in cycles 4, 8, 12; `bcd`=003. `hex` digit0=0110000, digits1–2=1111111.
- **Up carry and saturation:** load 098, enable up for 3 ticks → `bcd` 099, then 100, then 101 (digit2=1111001, digit1=1000000). Load 999, then tick → stays 999 with `at_limit`=1.
- **Countdown expiry:** load 002, `count_down`=1 → 001, then 000 with `expired` high for one cycle. A further tick keeps 000 with no `expired`.
- **Pause:** disable for 10 cycles at `div`=2 → `bcd` and `div` are unchanged. On re-enable, the next tick arrives after 3 enabled cycles.
- **Load priority:** assert `load`=0A5 (clamps to 095) in a tick cycle → `bcd`=095, and the next tick comes 4 enabled cycles later.
- **Blanking off and mid-run reset:** `BLANK_LEADING`=0 → `hex`=1000000 on all digits. Reset at `bcd`=057 mid-period → 000, and `expired` stays 0.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared constants and helpers for the BCD counter and its 7-segment displays.
// Segment patterns are active-low in gfedcba order.
package bcd_display_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// Single-digit BCD to active-low 7-segment decoder with a blanking input.
// Non-decimal codes also show blank so a corrupted digit never lights a bogus glyph.
module bcd_seg7_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    segments = SEG_0;
                4'd1:    segments = SEG_1;
                4'd2:    segments = SEG_2;
                4'd3:    segments = SEG_3;
                4'd4:    segments = SEG_4;
                4'd5:    segments = SEG_5;
                4'd6:    segments = SEG_6;
                4'd7:    segments = SEG_7;
                4'd8:    segments = SEG_8;
                4'd9:    segments = SEG_9;
                default: segments = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Enable-gated decimal event counter: rate divider, saturating BCD up/down count,
// parallel load, countdown-expiry pulse and per-digit 7-segment decode.
module bcd_tick_counter
    import bcd_display_pkg::*;
#(
    parameter int DIGITS        = 6,
    parameter int TICK_DIV      = 50_000_000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  count_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  tick,
    output logic                  at_limit,
    output logic                  expired
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TICK_DIV - 1);
    localparam int BCD_W = DIGIT_W * DIGITS;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              expired_q, expired_d;

    logic [BCD_W-1:0]  bcd_inc, bcd_dec, load_clamped;
    logic              is_zero, is_max;
    logic              tick_int;
    logic [DIGITS-1:0] lead_zero, blank;

    assign tick_int = enable && (div_q == '0);

    always_comb begin
        load_clamped = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_clamped[k*DIGIT_W +: DIGIT_W] = bcd_clamp(load_bcd[k*DIGIT_W +: DIGIT_W]);
        end
    end

    // Ripple carry: trailing 9s roll to 0 until the first digit that can absorb the +1.
    always_comb begin : inc_chain
        logic carry;
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (bcd_q[k*DIGIT_W +: DIGIT_W] == 4'd9) begin
                    bcd_inc[k*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    bcd_inc[k*DIGIT_W +: DIGIT_W] = bcd_q[k*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin : dec_chain
        logic borrow;
        bcd_dec = bcd_q;
        borrow  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (bcd_q[k*DIGIT_W +: DIGIT_W] == 4'd0) begin
                    bcd_dec[k*DIGIT_W +: DIGIT_W] = 4'd9;
                end else begin
                    bcd_dec[k*DIGIT_W +: DIGIT_W] = bcd_q[k*DIGIT_W +: DIGIT_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        is_zero = (bcd_q == '0);
        is_max  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[k*DIGIT_W +: DIGIT_W] != 4'd9) begin
                is_max = 1'b0;
            end
        end
    end

    // Load wins over a coincident tick and restarts the divider period.
    always_comb begin
        div_d     = div_q;
        bcd_d     = bcd_q;
        expired_d = 1'b0;
        if (load) begin
            bcd_d = load_clamped;
            div_d = DIV_RELOAD;
        end else begin
            if (enable) begin
                div_d = (div_q == '0) ? DIV_RELOAD : div_q - DIV_W'(1);
            end
            if (tick_int) begin
                if (count_down) begin
                    if (!is_zero) begin
                        bcd_d     = bcd_dec;
                        expired_d = (bcd_dec == '0);
                    end
                end else if (!is_max) begin
                    bcd_d = bcd_inc;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q     <= DIV_RELOAD;
            bcd_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            bcd_q     <= bcd_d;
            expired_q <= expired_d;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin : blank_chain
        logic above_zero;
        lead_zero  = '0;
        blank      = '0;
        above_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead_zero[k] = above_zero && (bcd_q[k*DIGIT_W +: DIGIT_W] == 4'd0);
            above_zero   = lead_zero[k];
            blank[k]     = (BLANK_LEADING != 0) && (k != 0) && lead_zero[k];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_seg7_decoder u_decoder (
            .digit    (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .blank    (blank[g]),
            .segments (hex[g*SEG_W +: SEG_W])
        );
    end

    assign bcd      = bcd_q;
    assign tick     = tick_int;
    assign at_limit = count_down ? is_zero : is_max;
    assign expired  = expired_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with DIGITS=3, TICK_DIV=4; a second
// instance with leading-zero blanking disabled shares the same stimulus.
module tb_bcd_tick_counter;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S9 = 7'b0011000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        count_down;
    logic        load;
    logic [11:0] load_bcd;
    logic [11:0] bcd, bcd_nb;
    logic [20:0] hex, hex_nb;
    logic        tick, tick_nb, at_limit, at_limit_nb, expired, expired_nb;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clock = ~clock;

    bcd_tick_counter #(.DIGITS(3), .TICK_DIV(4), .BLANK_LEADING(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .count_down(count_down),
        .load(load), .load_bcd(load_bcd), .bcd(bcd), .hex(hex), .tick(tick),
        .at_limit(at_limit), .expired(expired)
    );

    bcd_tick_counter #(.DIGITS(3), .TICK_DIV(4), .BLANK_LEADING(0)) dut_nb (
        .clock(clock), .reset(reset), .enable(enable), .count_down(count_down),
        .load(load), .load_bcd(load_bcd), .bcd(bcd_nb), .hex(hex_nb), .tick(tick_nb),
        .at_limit(at_limit_nb), .expired(expired_nb)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic [11:0] value, input logic dn);
        load       = ld;
        load_bcd   = value;
        count_down = dn;
        step();
        load = 1'b0;
    endtask

    // Counts cycles up to and including the one where tick is high, then steps past it.
    task automatic waitTick(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            if (tick) begin
                cycles = i;
                break;
            end
            step();
        end
        if (cycles != 0) step();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; count_down = 1'b0; load = 1'b0; load_bcd = '0;
        step();
        step();
        checkOutput("reset_bcd", 32'(bcd), 32'h000);
        checkOutput("reset_div", 32'(dut.div_q), 32'd3);
        checkOutput("reset_tick", 32'(tick), 32'd0);
        checkOutput("reset_expired", 32'(expired), 32'd0);
        checkOutput("reset_hex", 32'(hex), 32'({SB, SB, S0}));
        checkOutput("reset_hex_noblank", 32'(hex_nb), 32'({S0, S0, S0}));
        checkOutput("reset_at_limit", 32'(at_limit), 32'd0);

        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            checkOutput($sformatf("tick_cycle%0d", i), 32'(tick), 32'((i % 4) == 0));
            step();
        end
        checkOutput("first_ticks_bcd", 32'(bcd), 32'h003);
        checkOutput("first_ticks_hex", 32'(hex), 32'({SB, SB, S3}));

        applyStimulus(1'b1, 12'h098, 1'b0);
        checkOutput("load098_bcd", 32'(bcd), 32'h098);
        waitTick(n);
        checkOutput("up_first_period", 32'(n), 32'd4);
        checkOutput("up_099", 32'(bcd), 32'h099);
        waitTick(n);
        checkOutput("up_100", 32'(bcd), 32'h100);
        checkOutput("hex_100", 32'(hex), 32'({S1, S0, S0}));
        waitTick(n);
        checkOutput("up_101", 32'(bcd), 32'h101);
        checkOutput("hex_101", 32'(hex), 32'({S1, S0, S1}));

        applyStimulus(1'b1, 12'h999, 1'b0);
        checkOutput("load999_at_limit", 32'(at_limit), 32'd1);
        waitTick(n);
        checkOutput("sat_period", 32'(n), 32'd4);
        checkOutput("sat_999", 32'(bcd), 32'h999);
        checkOutput("sat_at_limit", 32'(at_limit), 32'd1);

        applyStimulus(1'b1, 12'h002, 1'b1);
        checkOutput("load002_at_limit", 32'(at_limit), 32'd0);
        waitTick(n);
        checkOutput("down_001", 32'(bcd), 32'h001);
        checkOutput("down_001_expired", 32'(expired), 32'd0);
        waitTick(n);
        checkOutput("down_000", 32'(bcd), 32'h000);
        checkOutput("expired_pulse", 32'(expired), 32'd1);
        step();
        checkOutput("expired_cleared", 32'(expired), 32'd0);
        checkOutput("zero_at_limit", 32'(at_limit), 32'd1);
        waitTick(n);
        checkOutput("zero_tick_period", 32'(n), 32'd3);
        checkOutput("zero_hold", 32'(bcd), 32'h000);
        checkOutput("zero_no_expired", 32'(expired), 32'd0);

        step();
        checkOutput("pause_div_before", 32'(dut.div_q), 32'd2);
        enable     = 1'b0;
        count_down = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checkOutput("pause_tick", 32'(tick), 32'd0);
        checkOutput("pause_bcd", 32'(bcd), 32'h000);
        checkOutput("pause_div", 32'(dut.div_q), 32'd2);
        enable = 1'b1;
        waitTick(n);
        checkOutput("resume_period", 32'(n), 32'd3);
        checkOutput("resume_bcd", 32'(bcd), 32'h001);

        step(); step(); step();
        checkOutput("pre_load_tick", 32'(tick), 32'd1);
        applyStimulus(1'b1, 12'h0A5, 1'b0);
        checkOutput("load_clamp_bcd", 32'(bcd), 32'h095);
        checkOutput("load_div_reload", 32'(dut.div_q), 32'd3);
        waitTick(n);
        checkOutput("post_load_period", 32'(n), 32'd4);
        checkOutput("post_load_bcd", 32'(bcd), 32'h096);
        checkOutput("hex_096", 32'(hex), 32'({SB, S9, S6}));
        checkOutput("hex_096_noblank", 32'(hex_nb), 32'({S0, S9, S6}));

        applyStimulus(1'b1, 12'h001, 1'b1);
        applyStimulus(1'b1, 12'h000, 1'b1);
        checkOutput("load_zero_no_expired", 32'(expired), 32'd0);
        step();
        checkOutput("load_zero_no_expired2", 32'(expired), 32'd0);

        applyStimulus(1'b1, 12'h057, 1'b1);
        step();
        checkOutput("midrun_div", 32'(dut.div_q), 32'd2);
        reset = 1'b0;
        step();
        checkOutput("midrun_reset_bcd", 32'(bcd), 32'h000);
        checkOutput("midrun_reset_div", 32'(dut.div_q), 32'd3);
        checkOutput("midrun_reset_expired", 32'(expired), 32'd0);
        reset = 1'b1;
        waitTick(n);
        checkOutput("after_reset_period", 32'(n), 32'd4);
        checkOutput("after_reset_bcd", 32'(bcd), 32'h000);
        checkOutput("after_reset_expired", 32'(expired), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
